// File: rtl/pipeline_page_sequencer.sv
//==============================================================================
// Module      : pipeline_page_sequencer
// Description : Launch controller for the A -> B -> C processing chain over
//               the ping-pong page buffers AB, AC and BC. Each stage runs a
//               small ap_ctrl_hs handshake FSM. Per-buffer write/read page
//               pointers and full-page counts decide when a stage may launch.
//               Optional macro SEQ_STALL_CNT_EN adds per-stage stall counters
//               (a_stall, b_stall, c_stall).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipeline_page_sequencer #(
   parameter int AB_PAGES = 2,
   parameter int AC_PAGES = 4,
   parameter int BC_PAGES = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en_proc,
   output logic                        a_start,
   output logic                        b_start,
   output logic                        c_start,
   input  logic                        a_ready,
   input  logic                        b_ready,
   input  logic                        c_ready,
   input  logic                        a_done,
   input  logic                        b_done,
   input  logic                        c_done,
   output logic [$clog2(AB_PAGES)-1:0] ab_page_w,
   output logic [$clog2(AB_PAGES)-1:0] ab_page_r,
   output logic [$clog2(AC_PAGES)-1:0] ac_page_w,
   output logic [$clog2(AC_PAGES)-1:0] ac_page_r,
   output logic [$clog2(BC_PAGES)-1:0] bc_page_w,
   output logic [$clog2(BC_PAGES)-1:0] bc_page_r,
   output logic [$clog2(AB_PAGES):0]   ab_count,
   output logic [$clog2(AC_PAGES):0]   ac_count,
   output logic [$clog2(BC_PAGES):0]   bc_count,
   output logic [2:0]                  busy,
`ifdef SEQ_STALL_CNT_EN
   output logic [15:0]                 a_stall,
   output logic [15:0]                 b_stall,
   output logic [15:0]                 c_stall,
`endif
   output logic                        proto_err
);

   localparam int AB_W = $clog2(AB_PAGES);
   localparam int AC_W = $clog2(AC_PAGES);
   localparam int BC_W = $clog2(BC_PAGES);

   // Count value meaning "every page of the buffer holds unconsumed data"
   localparam logic [AB_W:0] C_AB_FULL = (AB_W+1)'(AB_PAGES);
   localparam logic [AC_W:0] C_AC_FULL = (AC_W+1)'(AC_PAGES);
   localparam logic [BC_W:0] C_BC_FULL = (BC_W+1)'(BC_PAGES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_RUN    = 2'd2
   } stage_state_e;

   // Stage index 0 = A, 1 = B, 2 = C throughout
   stage_state_e        state_q [3];
   logic [2:0]          start_q;
   logic [2:0]          busy_q;
   logic                err_q;

   logic [2:0]          ready_d;
   logic [2:0]          done_d;
   logic [2:0]          launch_d;
   logic [2:0]          fin_d;

   logic [AB_W-1:0]     ab_wp_q, ab_rp_q;
   logic [AC_W-1:0]     ac_wp_q, ac_rp_q;
   logic [BC_W-1:0]     bc_wp_q, bc_rp_q;
   logic [AB_W:0]       ab_cnt_q;
   logic [AC_W:0]       ac_cnt_q;
   logic [BC_W:0]       bc_cnt_q;

   logic                ab_full_d, ac_full_d, bc_full_d;

   // Launch conditions from registered counts and per-stage completion events
   always_comb begin
      ready_d   = {c_ready, b_ready, a_ready};
      done_d    = {c_done, b_done, a_done};
      ab_full_d = (ab_cnt_q == C_AB_FULL);
      ac_full_d = (ac_cnt_q == C_AC_FULL);
      bc_full_d = (bc_cnt_q == C_BC_FULL);

      launch_d[0] = en_proc && !ab_full_d && !ac_full_d;
      launch_d[1] = (ab_cnt_q != '0) && !bc_full_d;
      launch_d[2] = (bc_cnt_q != '0) && (ac_cnt_q != '0);

      // A run completes on done in RUN, or on ready+done together in LAUNCH
      for (int i = 0; i < 3; i++) begin
         fin_d[i] = ((state_q[i] == ST_RUN) && done_d[i]) ||
                    ((state_q[i] == ST_LAUNCH) && ready_d[i] && done_d[i]);
      end
   end

   // Per-stage handshake FSMs with registered start/busy and sticky protocol error
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= ST_IDLE;
         end
         start_q <= '0;
         busy_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            case (state_q[i])
               ST_IDLE: begin
                  // Stray handshake from an idle core is flagged, otherwise ignored
                  if (ready_d[i] || done_d[i]) begin
                     err_q <= 1'b1;
                  end
                  if (launch_d[i]) begin
                     state_q[i] <= ST_LAUNCH;
                     start_q[i] <= 1'b1;
                     busy_q[i]  <= 1'b1;
                  end
               end
               ST_LAUNCH: begin
                  if (ready_d[i]) begin
                     start_q[i] <= 1'b0;
                     if (done_d[i]) begin
                        state_q[i] <= ST_IDLE;
                        busy_q[i]  <= 1'b0;
                     end else begin
                        state_q[i] <= ST_RUN;
                     end
                  end
               end
               ST_RUN: begin
                  // Returning to IDLE forces at least one IDLE cycle before relaunch
                  if (done_d[i]) begin
                     state_q[i] <= ST_IDLE;
                     busy_q[i]  <= 1'b0;
                  end
               end
               default: begin
                  state_q[i] <= ST_IDLE;
                  start_q[i] <= 1'b0;
                  busy_q[i]  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Page pointers and occupancy advance on run completion; producer and
   // consumer finishing together on one buffer leave its count unchanged
   always_ff @(posedge clk) begin
      if (reset) begin
         ab_wp_q  <= '0;
         ab_rp_q  <= '0;
         ac_wp_q  <= '0;
         ac_rp_q  <= '0;
         bc_wp_q  <= '0;
         bc_rp_q  <= '0;
         ab_cnt_q <= '0;
         ac_cnt_q <= '0;
         bc_cnt_q <= '0;
      end else begin
         if (fin_d[0]) begin
            ab_wp_q <= ab_wp_q + AB_W'(1);
            ac_wp_q <= ac_wp_q + AC_W'(1);
         end
         if (fin_d[1]) begin
            ab_rp_q <= ab_rp_q + AB_W'(1);
            bc_wp_q <= bc_wp_q + BC_W'(1);
         end
         if (fin_d[2]) begin
            bc_rp_q <= bc_rp_q + BC_W'(1);
            ac_rp_q <= ac_rp_q + AC_W'(1);
         end
         ab_cnt_q <= ab_cnt_q + {{AB_W{1'b0}}, fin_d[0]} - {{AB_W{1'b0}}, fin_d[1]};
         ac_cnt_q <= ac_cnt_q + {{AC_W{1'b0}}, fin_d[0]} - {{AC_W{1'b0}}, fin_d[2]};
         bc_cnt_q <= bc_cnt_q + {{BC_W{1'b0}}, fin_d[1]} - {{BC_W{1'b0}}, fin_d[2]};
      end
   end

   assign a_start   = start_q[0];
   assign b_start   = start_q[1];
   assign c_start   = start_q[2];
   assign busy      = busy_q;
   assign proto_err = err_q;
   assign ab_page_w = ab_wp_q;
   assign ab_page_r = ab_rp_q;
   assign ac_page_w = ac_wp_q;
   assign ac_page_r = ac_rp_q;
   assign bc_page_w = bc_wp_q;
   assign bc_page_r = bc_rp_q;
   assign ab_count  = ab_cnt_q;
   assign ac_count  = ac_cnt_q;
   assign bc_count  = bc_cnt_q;

`ifdef SEQ_STALL_CNT_EN
   logic [15:0] a_stall_q, b_stall_q;

   // Saturating count of cycles an idle stage has input but no free output page
   always_ff @(posedge clk) begin
      if (reset) begin
         a_stall_q <= '0;
         b_stall_q <= '0;
      end else begin
         if ((state_q[0] == ST_IDLE) && en_proc && (ab_full_d || ac_full_d) &&
             (a_stall_q != 16'hFFFF)) begin
            a_stall_q <= a_stall_q + 16'd1;
         end
         if ((state_q[1] == ST_IDLE) && (ab_cnt_q != '0) && bc_full_d &&
             (b_stall_q != 16'hFFFF)) begin
            b_stall_q <= b_stall_q + 16'd1;
         end
      end
   end

   assign a_stall = a_stall_q;
   assign b_stall = b_stall_q;
   // Stage C has no output buffer, so it can never be output-stalled
   assign c_stall = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_page_sequencer.sv
//==============================================================================
// Module      : tb_pipeline_page_sequencer
// Description : Self-checking bench for pipeline_page_sequencer. Emulated
//               stage cores answer start strobes with random latencies; a
//               reference model derives counts, pointers, busy flags and
//               launch timing from completed-run totals per stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipeline_page_sequencer;

   localparam int AB_PAGES = 2;
   localparam int AC_PAGES = 4;
   localparam int BC_PAGES = 2;

   logic clk = 1'b0;
   logic reset;
   logic en_proc, man_en, auto_en;
   logic [2:0] man_rdy, man_dn, auto_rdy, auto_dn;
   logic a_start, b_start, c_start;
   logic [$clog2(AB_PAGES)-1:0] ab_page_w, ab_page_r;
   logic [$clog2(AC_PAGES)-1:0] ac_page_w, ac_page_r;
   logic [$clog2(BC_PAGES)-1:0] bc_page_w, bc_page_r;
   logic [$clog2(AB_PAGES):0]   ab_count;
   logic [$clog2(AC_PAGES):0]   ac_count;
   logic [$clog2(BC_PAGES):0]   bc_count;
   logic [2:0] busy;
   logic proto_err;
   logic [2:0] rdy_w, dn_w, start_w;
`ifdef SEQ_STALL_CNT_EN
   logic [15:0] a_stall, b_stall, c_stall;
`endif

   assign en_proc = man_en | auto_en;
   assign rdy_w   = man_rdy | auto_rdy;
   assign dn_w    = man_dn | auto_dn;
   assign start_w = {c_start, b_start, a_start};

   always #5 clk = ~clk;

   pipeline_page_sequencer #(
      .AB_PAGES(AB_PAGES), .AC_PAGES(AC_PAGES), .BC_PAGES(BC_PAGES)
   ) dut (
      .clk(clk), .reset(reset), .en_proc(en_proc),
      .a_start(a_start), .b_start(b_start), .c_start(c_start),
      .a_ready(rdy_w[0]), .b_ready(rdy_w[1]), .c_ready(rdy_w[2]),
      .a_done(dn_w[0]), .b_done(dn_w[1]), .c_done(dn_w[2]),
      .ab_page_w(ab_page_w), .ab_page_r(ab_page_r),
      .ac_page_w(ac_page_w), .ac_page_r(ac_page_r),
      .bc_page_w(bc_page_w), .bc_page_r(bc_page_r),
      .ab_count(ab_count), .ac_count(ac_count), .bc_count(bc_count),
      .busy(busy),
`ifdef SEQ_STALL_CNT_EN
      .a_stall(a_stall), .b_stall(b_stall), .c_stall(c_stall),
`endif
      .proto_err(proto_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Bench control
   bit auto_on = 1'b0;
   bit chk_on  = 1'b0;
   bit allow [3];
   int en_mode = 0;      // 0: off, 1: until target launches of A, 2: random
   int target  = 0;
   int comp [3];         // completed runs per stage (done accepted by the core protocol)

   // Emulated stage cores: ready after 0..2 cycles, done after 0..4 more
   // (or together with ready), one run at a time
   initial begin : p_cores
      int phase [3];
      int dly [3];
      auto_rdy = '0;
      auto_dn  = '0;
      for (int s = 0; s < 3; s++) begin
         phase[s] = 0; dly[s] = 0; comp[s] = 0;
      end
      forever begin
         @(negedge clk);
         for (int s = 0; s < 3; s++) begin
            auto_rdy[s] = 1'b0;
            auto_dn[s]  = 1'b0;
            if (reset || !auto_on) begin
               phase[s] = 0;
               dly[s]   = 0;
               if (reset) comp[s] = 0;
            end else begin
               if (phase[s] == 0 && start_w[s] && allow[s]) begin
                  phase[s] = 1;
                  dly[s]   = $urandom_range(0, 2);
               end
               if (phase[s] == 1) begin
                  if (dly[s] == 0) begin
                     auto_rdy[s] = 1'b1;
                     if ($urandom_range(0, 3) == 0) begin
                        auto_dn[s] = 1'b1;
                        comp[s]++;
                        phase[s] = 0;
                     end else begin
                        phase[s] = 2;
                        dly[s]   = $urandom_range(0, 4);
                     end
                  end else begin
                     dly[s]--;
                  end
               end else if (phase[s] == 2) begin
                  if (dly[s] == 0) begin
                     auto_dn[s] = 1'b1;
                     comp[s]++;
                     phase[s] = 0;
                  end else begin
                     dly[s]--;
                  end
               end
            end
         end
      end
   end

   // Event source for en_proc
   initial begin : p_events
      int a_launch;
      logic a_prev;
      a_launch = 0;
      a_prev   = 1'b0;
      auto_en  = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            a_launch = 0;
         end else if (a_start && !a_prev) begin
            a_launch++;
         end
         a_prev = a_start;
         case (en_mode)
            1:       auto_en = (a_launch < target);
            2:       auto_en = ($urandom_range(0, 2) != 0);
            default: auto_en = 1'b0;
         endcase
      end
   end

   // Reference model: occupancy = producer completions - consumer completions,
   // pointers = completions mod page count, a stage is busy between its
   // launch and its completion, and an idle stage whose launch rule held in
   // one cycle must show a fresh start in the next.
   initial begin : p_model
      int  nl [3];
      bit  pidle [3];
      bit  pcond [3];
      bit  rise, exp_rise;
      int  mab, mac, mbc;
      logic [2:0] sprev;
      for (int s = 0; s < 3; s++) begin
         nl[s] = 0; pidle[s] = 1'b1; pcond[s] = 1'b0;
      end
      sprev = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!chk_on || reset) begin
            for (int s = 0; s < 3; s++) begin
               nl[s] = 0; pidle[s] = 1'b1;
            end
            pcond[0] = 1'b1;
            pcond[1] = 1'b0;
            pcond[2] = 1'b0;
            sprev    = start_w;
         end else begin
            for (int s = 0; s < 3; s++) begin
               rise     = start_w[s] && !sprev[s];
               exp_rise = pidle[s] && pcond[s] && ((s != 0) || en_proc);
               check($sformatf("launch[%0d]", s), int'(rise), int'(exp_rise));
               if (rise) nl[s]++;
               check($sformatf("busy[%0d]", s), int'(busy[s]), int'(nl[s] != comp[s]));
            end
            mab = comp[0] - comp[1];
            mac = comp[0] - comp[2];
            mbc = comp[1] - comp[2];
            check("m_ab_count", int'(ab_count), mab);
            check("m_ac_count", int'(ac_count), mac);
            check("m_bc_count", int'(bc_count), mbc);
            check("m_ab_page_w", int'(ab_page_w), comp[0] % AB_PAGES);
            check("m_ab_page_r", int'(ab_page_r), comp[1] % AB_PAGES);
            check("m_ac_page_w", int'(ac_page_w), comp[0] % AC_PAGES);
            check("m_ac_page_r", int'(ac_page_r), comp[2] % AC_PAGES);
            check("m_bc_page_w", int'(bc_page_w), comp[1] % BC_PAGES);
            check("m_bc_page_r", int'(bc_page_r), comp[2] % BC_PAGES);
            check("m_proto_err", int'(proto_err), 0);
            for (int s = 0; s < 3; s++) pidle[s] = (nl[s] == comp[s]);
            pcond[0] = (mab < AB_PAGES) && (mac < AC_PAGES);
            pcond[1] = (mab > 0) && (mbc < BC_PAGES);
            pcond[2] = (mbc > 0) && (mac > 0);
            sprev    = start_w;
         end
      end
   end

   typedef struct {
      string    name;
      int       events;
      bit       allow_b;
      bit       allow_c;
      int       runs_a;
      int       ab, ac, bc;
      int       abw, abr, acw, acr, bcw, bcr;
      int       busy;
   } vec_t;

   vec_t vecs [5];

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start"}, int'(start_w), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_counts"}, int'(ab_count) + int'(ac_count) + int'(bc_count), 0);
      check({tag, "_ptrs"}, int'(ab_page_w) + int'(ab_page_r) + int'(ac_page_w) +
            int'(ac_page_r) + int'(bc_page_w) + int'(bc_page_r), 0);
      check({tag, "_proto_err"}, int'(proto_err), 0);
   endtask

   initial begin : p_main
      reset   = 1'b1;
      man_en  = 1'b0;
      man_rdy = '0;
      man_dn  = '0;
      for (int s = 0; s < 3; s++) allow[s] = 1'b1;

      //            name         ev   B  C  runs ab ac bc abw abr acw acr bcw bcr busy
      vecs[0] = '{"single",       1, 1, 1, 1,   0, 0, 0, 1,  1,  1,  1,  1,  1,  0};
      vecs[1] = '{"backpressure", 999, 1, 0, 4,  2, 4, 2, 0,  0,  0,  0,  0,  0,  4};
      vecs[2] = '{"ac_depth",     999, 0, 1, 2,  2, 2, 0, 0,  0,  2,  0,  0,  0,  2};
      vecs[3] = '{"wrap5",        5, 1, 1, 5,   0, 0, 0, 1,  1,  1,  1,  1,  1,  0};
      vecs[4] = '{"three",        3, 1, 1, 3,   0, 0, 0, 1,  1,  3,  3,  1,  1,  0};

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // Table-driven scenarios run to quiescence
      for (int i = 0; i < 5; i++) begin
         reset    = 1'b1;
         allow[0] = 1'b1;
         allow[1] = vecs[i].allow_b;
         allow[2] = vecs[i].allow_c;
         target   = vecs[i].events;
         en_mode  = 1;
         auto_on  = 1'b1;
         chk_on   = 1'b1;
         repeat (2) @(negedge clk);
         reset = 1'b0;
         repeat (200) @(negedge clk);
         check({vecs[i].name, "_runs_a"}, comp[0], vecs[i].runs_a);
         check({vecs[i].name, "_ab_count"}, int'(ab_count), vecs[i].ab);
         check({vecs[i].name, "_ac_count"}, int'(ac_count), vecs[i].ac);
         check({vecs[i].name, "_bc_count"}, int'(bc_count), vecs[i].bc);
         check({vecs[i].name, "_ab_page_w"}, int'(ab_page_w), vecs[i].abw);
         check({vecs[i].name, "_ab_page_r"}, int'(ab_page_r), vecs[i].abr);
         check({vecs[i].name, "_ac_page_w"}, int'(ac_page_w), vecs[i].acw);
         check({vecs[i].name, "_ac_page_r"}, int'(ac_page_r), vecs[i].acr);
         check({vecs[i].name, "_bc_page_w"}, int'(bc_page_w), vecs[i].bcw);
         check({vecs[i].name, "_bc_page_r"}, int'(bc_page_r), vecs[i].bcr);
         check({vecs[i].name, "_busy"}, int'(busy), vecs[i].busy);
         check({vecs[i].name, "_a_start"}, int'(a_start), 0);
      end

      // Randomised event stream, then drain
      reset    = 1'b1;
      for (int s = 0; s < 3; s++) allow[s] = 1'b1;
      en_mode  = 2;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3000) @(negedge clk);
      en_mode = 0;
      repeat (200) @(negedge clk);
      check("rand_drained_counts", int'(ab_count) + int'(ac_count) + int'(bc_count), 0);
      check("rand_busy", int'(busy), 0);
      check("rand_ac_ptr_agree", int'(ac_page_w), int'(ac_page_r));

      // Hand-driven sequences: simultaneous A/B done, mid-run reset, stray done
      reset   = 1'b1;
      auto_on = 1'b0;
      chk_on  = 1'b0;
      en_mode = 0;
      do_reset();
      man_en = 1'b1;
      @(negedge clk);
      check("seq_a_start", int'(start_w), 3'b001);
      man_rdy[0] = 1'b1;
      man_dn[0]  = 1'b1;
      man_en     = 1'b0;
      @(negedge clk);
      man_rdy = '0;
      man_dn  = '0;
      check("seq_ab_after_a", int'(ab_count), 1);
      check("seq_abw_after_a", int'(ab_page_w), 1);
      man_en = 1'b1;
      @(negedge clk);
      check("seq_ab_launch", int'(start_w), 3'b011);
      man_en  = 1'b0;
      man_rdy = 3'b011;
      @(negedge clk);
      man_rdy = '0;
      man_dn  = 3'b011;
      check("seq_ab_running", int'(busy), 3'b011);
      check("seq_starts_dropped", int'(start_w), 0);
      @(negedge clk);
      man_dn = '0;
      check("simul_ab_count", int'(ab_count), 1);
      check("simul_ab_page_w", int'(ab_page_w), 0);
      check("simul_ab_page_r", int'(ab_page_r), 1);
      check("simul_ac_count", int'(ac_count), 2);
      check("simul_bc_count", int'(bc_count), 1);
      @(negedge clk);
      check("seq_bc_launch", int'(start_w), 3'b110);
      man_rdy[1] = 1'b1;
      @(negedge clk);
      man_rdy = '0;
      check("seq_b_run_busy", int'(busy), 3'b110);
      check("seq_pre_rst_ab", int'(ab_count), 1);
      check("seq_pre_rst_bc", int'(bc_count), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_all_zero("midrst");
      @(negedge clk);
      check("midrst_no_start", int'(start_w), 0);
      man_dn[1] = 1'b1;
      @(negedge clk);
      man_dn = '0;
      check("stray_proto_err", int'(proto_err), 1);
      check("stray_ignored", int'(ab_count) + int'(bc_count) + int'(busy), 0);
      @(negedge clk);
      check("proto_err_sticky", int'(proto_err), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
